// File: rtl/spi_cs_arbiter_if.sv
// Bundle of requester-side and SPI-master-side signals for spi_cs_arbiter.
// Signal names keep the arbiter's point of view: i_* flow into it, o_* flow out of it.
//
// Handshake: a requester may pulse i_Req_DV[r] for one cycle only while
// o_Req_Ready[r] is high. Ready then drops until the byte's RX has come back.
// o_SPI_TX_DV is a one-cycle strobe issued only while the master reported
// i_SPI_TX_Ready. i_SPI_RX_DV and o_Req_RX_DV are one-cycle valids with no
// back-pressure.
interface spi_cs_arbiter_if #(
  parameter int CNT_W = 2
);
  logic [1:0]         i_Req;
  logic [2*CNT_W-1:0] i_Req_Count;
  logic [15:0]        i_Req_Byte;
  logic [1:0]         i_Req_DV;
  logic [1:0]         o_Grant;
  logic [1:0]         o_Req_Ready;
  logic [1:0]         o_Req_RX_DV;
  logic [7:0]         o_Req_RX_Byte;
  logic [1:0]         o_Req_Done;
  logic [CNT_W-1:0]   o_SPI_TX_Count;
  logic [7:0]         o_SPI_TX_Byte;
  logic               o_SPI_TX_DV;
  logic               i_SPI_TX_Ready;
  logic               i_SPI_RX_DV;
  logic [7:0]         i_SPI_RX_Byte;

  modport slave (
    input  i_Req, i_Req_Count, i_Req_Byte, i_Req_DV,
    input  i_SPI_TX_Ready, i_SPI_RX_DV, i_SPI_RX_Byte,
    output o_Grant, o_Req_Ready, o_Req_RX_DV, o_Req_RX_Byte, o_Req_Done,
    output o_SPI_TX_Count, o_SPI_TX_Byte, o_SPI_TX_DV
  );

  modport master (
    output i_Req, i_Req_Count, i_Req_Byte, i_Req_DV,
    output i_SPI_TX_Ready, i_SPI_RX_DV, i_SPI_RX_Byte,
    input  o_Grant, o_Req_Ready, o_Req_RX_DV, o_Req_RX_Byte, o_Req_Done,
    input  o_SPI_TX_Count, o_SPI_TX_Byte, o_SPI_TX_DV
  );
endinterface

// File: rtl/spi_cs_arbiter.sv
// Two-requester arbiter in front of one single-CS SPI master: grants a whole
// CS transaction to one requester, forwards its TX bytes and routes RX back.
module spi_cs_arbiter #(
  parameter int MAX_BYTES_PER_CS = 2,
  parameter int CNT_W            = 2,
  parameter int RELEASE_GAP      = 2
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  spi_cs_arbiter_if.slave  bus,
  output logic [1:0]       o_Dbg_State
);

  localparam int GAP_W = (RELEASE_GAP > 2) ? $clog2(RELEASE_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = (RELEASE_GAP > 1) ? GAP_W'(RELEASE_GAP - 1) : '0;
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_BYTES_PER_CS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_XFER    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tx_sent_q, tx_sent_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic             pending_q, pending_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [1:0]       grant_q, grant_d;
  logic [1:0]       ready_q, ready_d;
  logic [1:0]       rx_dv_q, rx_dv_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic [1:0]       done_q, done_d;
  logic [CNT_W-1:0] tx_count_q, tx_count_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             tx_dv_q, tx_dv_d;

  logic             pick;
  logic [CNT_W-1:0] raw_cnt;
  logic [CNT_W-1:0] clamp_cnt;
  logic [7:0]       g_byte;
  logic             accept;

  // Round-robin pick: the preferred requester if it asks, else the other one.
  assign pick      = bus.i_Req[ptr_q] ? ptr_q : ~ptr_q;
  assign raw_cnt   = pick ? bus.i_Req_Count[2*CNT_W-1:CNT_W] : bus.i_Req_Count[CNT_W-1:0];
  assign clamp_cnt = (raw_cnt > MAX_CNT) ? MAX_CNT : raw_cnt;
  assign g_byte    = sel_q ? bus.i_Req_Byte[15:8] : bus.i_Req_Byte[7:0];
  assign accept    = (state_q == S_XFER) && bus.i_Req_DV[sel_q] && ready_q[sel_q];

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    tx_sent_d  = tx_sent_q;
    rx_cnt_d   = rx_cnt_q;
    pending_d  = pending_q;
    gap_d      = gap_q;
    grant_d    = grant_q;
    ready_d    = 2'b00;
    rx_dv_d    = 2'b00;
    rx_byte_d  = rx_byte_q;
    done_d     = 2'b00;
    tx_count_d = tx_count_q;
    tx_byte_d  = tx_byte_q;
    tx_dv_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        gap_d = '0;
        if (|bus.i_Req) begin
          sel_d     = pick;
          cnt_d     = clamp_cnt;
          ptr_d     = ~pick;
          tx_sent_d = '0;
          rx_cnt_d  = '0;
          pending_d = 1'b0;
          if (clamp_cnt == '0) begin
            // Empty transaction: acknowledge without touching the master.
            done_d[pick] = 1'b1;
            state_d      = S_RELEASE;
          end else begin
            grant_d       = 2'b00;
            grant_d[pick] = 1'b1;
            tx_count_d    = clamp_cnt;
            ready_d[pick] = bus.i_SPI_TX_Ready;
            state_d       = S_XFER;
          end
        end
      end

      S_XFER: begin
        if (bus.i_SPI_RX_DV) begin
          rx_dv_d[sel_q] = 1'b1;
          rx_byte_d      = bus.i_SPI_RX_Byte;
          rx_cnt_d       = rx_cnt_q + 1'b1;
          pending_d      = 1'b0;
          if (rx_cnt_d == cnt_q) begin
            done_d[sel_q] = 1'b1;
            state_d       = S_RELEASE;
          end
        end
        if (accept) begin
          tx_dv_d   = 1'b1;
          tx_byte_d = g_byte;
          tx_sent_d = tx_sent_q + 1'b1;
          pending_d = 1'b1;
        end
        // Ready is registered, so it is derived from next-cycle counters.
        ready_d[sel_q] = (state_d == S_XFER) && bus.i_SPI_TX_Ready &&
                         !pending_d && (tx_sent_d < cnt_q);
      end

      S_RELEASE: begin
        grant_d = 2'b00;
        if ((gap_q == GAP_LAST) && bus.i_SPI_TX_Ready) begin
          state_d = S_IDLE;
          gap_d   = '0;
        end else if (gap_q != GAP_LAST) begin
          gap_d = gap_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q    <= S_IDLE;
      ptr_q      <= 1'b0;
      sel_q      <= 1'b0;
      cnt_q      <= '0;
      tx_sent_q  <= '0;
      rx_cnt_q   <= '0;
      pending_q  <= 1'b0;
      gap_q      <= '0;
      grant_q    <= 2'b00;
      ready_q    <= 2'b00;
      rx_dv_q    <= 2'b00;
      rx_byte_q  <= 8'h00;
      done_q     <= 2'b00;
      tx_count_q <= '0;
      tx_byte_q  <= 8'h00;
      tx_dv_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      tx_sent_q  <= tx_sent_d;
      rx_cnt_q   <= rx_cnt_d;
      pending_q  <= pending_d;
      gap_q      <= gap_d;
      grant_q    <= grant_d;
      ready_q    <= ready_d;
      rx_dv_q    <= rx_dv_d;
      rx_byte_q  <= rx_byte_d;
      done_q     <= done_d;
      tx_count_q <= tx_count_d;
      tx_byte_q  <= tx_byte_d;
      tx_dv_q    <= tx_dv_d;
    end
  end

  assign bus.o_Grant        = grant_q;
  assign bus.o_Req_Ready    = ready_q;
  assign bus.o_Req_RX_DV    = rx_dv_q;
  assign bus.o_Req_RX_Byte  = rx_byte_q;
  assign bus.o_Req_Done     = done_q;
  assign bus.o_SPI_TX_Count = tx_count_q;
  assign bus.o_SPI_TX_Byte  = tx_byte_q;
  assign bus.o_SPI_TX_DV    = tx_dv_q;
  assign o_Dbg_State        = state_q;

endmodule

// File: tb/tb_spi_cs_arbiter.sv
// Directed bench for spi_cs_arbiter with a loopback single-CS SPI master model.
module tb_spi_cs_arbiter;
  localparam int CNT_W = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  spi_cs_arbiter_if #(.CNT_W(CNT_W)) bus ();

  spi_cs_arbiter #(
    .MAX_BYTES_PER_CS(2),
    .CNT_W(CNT_W),
    .RELEASE_GAP(2)
  ) dut (
    .i_Clk(clk),
    .i_Rst_L(rst_n),
    .bus(bus),
    .o_Dbg_State(dbg_state)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // SPI master model: loopback, 3 clocks per byte, CS held low for the
  // latched count, then a 5-clock CS-inactive gap with TX_Ready low.
  int         cyc = 0;
  logic       m_busy = 1'b0;
  int         m_timer = 0;
  int         m_left = 0;
  int         gap_t = 0;
  logic [7:0] m_byte = 8'h00;
  logic       cs_n = 1'b1;
  int         cs_fall = 0;
  int         cs_rise = 0;
  int         ready_rise_cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      bus.i_SPI_TX_Ready = 1'b1;
      bus.i_SPI_RX_DV    = 1'b0;
      bus.i_SPI_RX_Byte  = 8'h00;
      cs_n   = 1'b1;
      m_busy = 1'b0;
      gap_t  = 0;
      m_left = 0;
    end else begin
      bus.i_SPI_RX_DV = 1'b0;
      if (bus.o_SPI_TX_DV) begin
        if (cs_n) begin
          cs_n = 1'b0;
          cs_fall++;
          m_left = int'(bus.o_SPI_TX_Count);
        end
        m_byte  = bus.o_SPI_TX_Byte;
        bus.i_SPI_TX_Ready = 1'b0;
        m_busy  = 1'b1;
        m_timer = 3;
      end else if (m_busy) begin
        m_timer--;
        if (m_timer == 0) begin
          m_busy = 1'b0;
          bus.i_SPI_RX_DV   = 1'b1;
          bus.i_SPI_RX_Byte = m_byte;
          m_left--;
          if (m_left <= 0) begin
            cs_n = 1'b1;
            cs_rise++;
            gap_t = 5;
          end else begin
            bus.i_SPI_TX_Ready = 1'b1;
          end
        end
      end else if (gap_t > 0) begin
        gap_t--;
        if (gap_t == 0) begin
          bus.i_SPI_TX_Ready = 1'b1;
          ready_rise_cyc = cyc;
        end
      end
    end
  end

  // Monitor: logs SPI strobes, routed RX bytes and done pulses.
  logic [7:0] spi_log[$];
  logic [7:0] rx_log0[$];
  logic [7:0] rx_log1[$];
  logic [7:0] exp_q[$];
  int         done_cnt[2];
  logic       done_had_rx[2];
  int         grant_both = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_SPI_TX_DV) spi_log.push_back(bus.o_SPI_TX_Byte);
      if (bus.o_Req_RX_DV[0]) rx_log0.push_back(bus.o_Req_RX_Byte);
      if (bus.o_Req_RX_DV[1]) rx_log1.push_back(bus.o_Req_RX_Byte);
      for (int r = 0; r < 2; r++) begin
        if (bus.o_Req_Done[r]) begin
          done_cnt[r]++;
          done_had_rx[r] = bus.o_Req_RX_DV[r];
        end
      end
      if (bus.o_Grant == 2'b11) grant_both++;
    end
  end

  task automatic clear_logs();
    spi_log.delete();
    rx_log0.delete();
    rx_log1.delete();
    exp_q.delete();
  endtask

  task automatic check_logs(input string name, input int r);
    chk({name, "_spi_n"}, spi_log.size(), exp_q.size());
    chk({name, "_rx_n"}, (r == 0) ? rx_log0.size() : rx_log1.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      chk({name, "_spi_b"}, (i < spi_log.size()) ? spi_log[i] : 8'hxx, exp_q[i]);
      if (r == 0) chk({name, "_rx_b"}, (i < rx_log0.size()) ? rx_log0[i] : 8'hxx, exp_q[i]);
      else        chk({name, "_rx_b"}, (i < rx_log1.size()) ? rx_log1[i] : 8'hxx, exp_q[i]);
    end
  endtask

  task automatic set_count(input int r, input int cnt);
    logic [31:0] c;
    c = cnt;
    if (r == 0) bus.i_Req_Count[CNT_W-1:0] = c[CNT_W-1:0];
    else        bus.i_Req_Count[2*CNT_W-1:CNT_W] = c[CNT_W-1:0];
  endtask

  task automatic set_byte(input int r, input logic [7:0] b);
    if (r == 0) bus.i_Req_Byte[7:0] = b;
    else        bus.i_Req_Byte[15:8] = b;
  endtask

  task automatic wait_grant(input int r, output logic ok, output logic [31:0] txc);
    ok = 1'b0;
    txc = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.o_Grant[r]) begin
        ok = 1'b1;
        txc = 32'(bus.o_SPI_TX_Count);
        break;
      end
      if (bus.o_Req_Done[r]) break;
    end
  endtask

  // Strobes bytes[8*k +: 8] whenever Ready is seen, until done or budget.
  task automatic send_bytes(input int r, input logic [23:0] bytes, input int nsend, output logic to);
    int sent;
    sent = 0;
    to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      bus.i_Req_DV[r] = 1'b0;
      if (bus.o_Req_Done[r]) begin
        to = 1'b0;
        break;
      end
      if (sent < nsend && bus.o_Req_Ready[r]) begin
        bus.i_Req_DV[r] = 1'b1;
        set_byte(r, bytes[8*sent +: 8]);
        sent++;
      end
      @(negedge clk);
    end
    bus.i_Req_DV[r] = 1'b0;
  endtask

  typedef struct {
    int          r;
    int          cnt;
    logic [23:0] bytes;
    int          nsend;
    int          exp_n;
    int          exp_txc;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic        ok;
    logic        to;
    logic [31:0] txc;
    int          d0, d1, cf, cr, g1_cyc;

    bus.i_Req = 2'b00;
    bus.i_Req_Count = '0;
    bus.i_Req_Byte = 16'h0000;
    bus.i_Req_DV = 2'b00;
    done_cnt[0] = 0;
    done_cnt[1] = 0;

    vecs[0] = '{r: 0, cnt: 2, bytes: 24'h00_C2_C1, nsend: 2, exp_n: 2, exp_txc: 2};
    vecs[1] = '{r: 1, cnt: 1, bytes: 24'h00_00_5A, nsend: 1, exp_n: 1, exp_txc: 1};
    vecs[2] = '{r: 0, cnt: 0, bytes: 24'h00_00_EE, nsend: 1, exp_n: 0, exp_txc: 0};
    vecs[3] = '{r: 1, cnt: 3, bytes: 24'h33_22_11, nsend: 3, exp_n: 2, exp_txc: 2};
    vecs[4] = '{r: 1, cnt: 2, bytes: 24'h00_C3_3C, nsend: 2, exp_n: 2, exp_txc: 2};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_grant", bus.o_Grant, 2'b00);
    chk("rst_ready", bus.o_Req_Ready, 2'b00);
    chk("rst_done", bus.o_Req_Done, 2'b00);
    chk("rst_spi_dv", bus.o_SPI_TX_DV, 1'b0);
    chk("rst_state", dbg_state, 2'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Simultaneous requests right after reset: req0 first, req1 after the CS gap
    clear_logs();
    ready_rise_cyc = 1000000;
    d0 = done_cnt[0];
    d1 = done_cnt[1];
    set_count(0, 1);
    set_count(1, 1);
    bus.i_Req = 2'b11;
    wait_grant(0, ok, txc);
    chk("a_grant0_ok", ok, 1'b1);
    chk("a_grant_first", bus.o_Grant, 2'b01);
    bus.i_Req[0] = 1'b0;
    send_bytes(0, 24'h0000A5, 1, to);
    chk("a_req0_timeout", to, 1'b0);
    wait_grant(1, ok, txc);
    g1_cyc = cyc;
    bus.i_Req[1] = 1'b0;
    chk("a_grant1_ok", ok, 1'b1);
    chk("a_grant1_after_ready", g1_cyc > ready_rise_cyc, 1'b1);
    send_bytes(1, 24'h00005A, 1, to);
    chk("a_req1_timeout", to, 1'b0);
    repeat (12) @(negedge clk);
    chk("a_spi_n", spi_log.size(), 2);
    chk("a_spi_0", (spi_log.size() > 0) ? spi_log[0] : 8'hxx, 8'hA5);
    chk("a_spi_1", (spi_log.size() > 1) ? spi_log[1] : 8'hxx, 8'h5A);
    chk("a_rx0", (rx_log0.size() == 1) ? rx_log0[0] : 8'hxx, 8'hA5);
    chk("a_rx1", (rx_log1.size() == 1) ? rx_log1[0] : 8'hxx, 8'h5A);
    chk("a_done0", done_cnt[0] - d0, 1);
    chk("a_done1", done_cnt[1] - d1, 1);
    chk("a_grant_never_both", grant_both, 0);

    // Single-requester transactions from the table
    for (int v = 0; v < 5; v++) begin
      clear_logs();
      for (int k = 0; k < vecs[v].exp_n; k++) exp_q.push_back(vecs[v].bytes[8*k +: 8]);
      d0 = done_cnt[vecs[v].r];
      cf = cs_fall;
      cr = cs_rise;
      set_count(vecs[v].r, vecs[v].cnt);
      bus.i_Req[vecs[v].r] = 1'b1;
      wait_grant(vecs[v].r, ok, txc);
      bus.i_Req[vecs[v].r] = 1'b0;
      chk($sformatf("v%0d_granted", v), ok, (vecs[v].exp_n > 0));
      if (ok) begin
        chk($sformatf("v%0d_tx_count", v), txc, vecs[v].exp_txc);
        send_bytes(vecs[v].r, vecs[v].bytes, vecs[v].nsend, to);
        chk($sformatf("v%0d_timeout", v), to, 1'b0);
        chk($sformatf("v%0d_done_with_rx", v), done_had_rx[vecs[v].r], 1'b1);
      end
      repeat (15) @(negedge clk);
      chk($sformatf("v%0d_done", v), done_cnt[vecs[v].r] - d0, 1);
      chk($sformatf("v%0d_cs_fall", v), cs_fall - cf, (vecs[v].exp_n > 0));
      chk($sformatf("v%0d_cs_rise", v), cs_rise - cr, (vecs[v].exp_n > 0));
      check_logs($sformatf("v%0d", v), vecs[v].r);
    end

    // Non-granted requester strobes while req0 holds the grant
    clear_logs();
    exp_q.push_back(8'h3C);
    set_count(0, 1);
    bus.i_Req[0] = 1'b1;
    wait_grant(0, ok, txc);
    bus.i_Req[0] = 1'b0;
    chk("b_grant0", ok, 1'b1);
    bus.i_Req_DV[1] = 1'b1;
    set_byte(1, 8'hFF);
    @(negedge clk);
    bus.i_Req_DV[1] = 1'b0;
    send_bytes(0, 24'h00003C, 1, to);
    chk("b_timeout", to, 1'b0);
    repeat (15) @(negedge clk);
    check_logs("b", 0);
    chk("b_rx1_empty", rx_log1.size(), 0);

    // Double strobe during one byte
    clear_logs();
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    set_count(0, 2);
    bus.i_Req[0] = 1'b1;
    wait_grant(0, ok, txc);
    bus.i_Req[0] = 1'b0;
    chk("c_ready_at_grant", bus.o_Req_Ready[0], 1'b1);
    bus.i_Req_DV[0] = 1'b1;
    set_byte(0, 8'h11);
    @(negedge clk);
    chk("c_ready_after_accept", bus.o_Req_Ready[0], 1'b0);
    set_byte(0, 8'h99);
    @(negedge clk);
    bus.i_Req_DV[0] = 1'b0;
    @(negedge clk);
    chk("c_one_strobe", spi_log.size(), 1);
    send_bytes(0, 24'h000022, 1, to);
    chk("c_timeout", to, 1'b0);
    repeat (15) @(negedge clk);
    check_logs("c", 0);

    // Reset mid-transaction, then a fresh req1 transaction
    clear_logs();
    d0 = done_cnt[0];
    set_count(0, 2);
    bus.i_Req[0] = 1'b1;
    wait_grant(0, ok, txc);
    bus.i_Req[0] = 1'b0;
    chk("d_grant0", ok, 1'b1);
    bus.i_Req_DV[0] = 1'b1;
    set_byte(0, 8'hD1);
    @(negedge clk);
    bus.i_Req_DV[0] = 1'b0;
    for (int i = 0; i < 20 && rx_log0.size() == 0; i++) @(negedge clk);
    chk("d_first_rx", rx_log0.size(), 1);
    rst_n = 1'b0;
    #1;
    chk("d_rst_grant", bus.o_Grant, 2'b00);
    chk("d_rst_ready", bus.o_Req_Ready, 2'b00);
    chk("d_rst_tx_count", bus.o_SPI_TX_Count, 2'd0);
    chk("d_rst_tx_byte", bus.o_SPI_TX_Byte, 8'h00);
    chk("d_rst_rx_byte", bus.o_Req_RX_Byte, 8'h00);
    chk("d_rst_state", dbg_state, 2'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("d_no_done", done_cnt[0] - d0, 0);
    clear_logs();
    exp_q.push_back(8'h77);
    d1 = done_cnt[1];
    set_count(1, 1);
    bus.i_Req[1] = 1'b1;
    wait_grant(1, ok, txc);
    bus.i_Req[1] = 1'b0;
    chk("d_grant1", ok, 1'b1);
    send_bytes(1, 24'h000077, 1, to);
    chk("d_timeout", to, 1'b0);
    repeat (15) @(negedge clk);
    chk("d_done1", done_cnt[1] - d1, 1);
    check_logs("d", 1);
    chk("d_grant_never_both", grant_both, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_cs_arbiter.md
Name: spi_cs_arbiter

Overview:
- Shares one SPI_Master_With_Single_CS instance between two requesters.
- Grants one requester at a time, for a whole chip-select transaction of N bytes.
- Forwards that requester's TX bytes to the master and routes the master's RX bytes back to it.
- Sits between client logic (register-access engine, flash loader) and the SPI master's TX/RX byte interface.

Parameters:
- MAX_BYTES_PER_CS, 2: maximum bytes per CS transaction; must equal the master's MAX_BYTES_PER_CS.
- CNT_W, 2: width of byte-count fields; must satisfy 2^CNT_W > MAX_BYTES_PER_CS.
- RELEASE_GAP, 2: minimum clocks spent in RELEASE before a new grant is allowed.

Ports:
- i_Clk  in  1  system clock.
- i_Rst_L  in  1  asynchronous, active-low reset.
- i_Req  in  2  transaction request, bit r = requester r; level, held until o_Grant[r].
- i_Req_Count  in  2*CNT_W  bytes requested; [CNT_W-1:0] = req0, [2*CNT_W-1:CNT_W] = req1.
- i_Req_Byte  in  16  TX byte; [7:0] = req0, [15:8] = req1.
- i_Req_DV  in  2  one-cycle TX byte strobe per requester.
- o_Grant  out  2  one-hot grant, held for the whole transaction.
- o_Req_Ready  out  2  granted requester may strobe i_Req_DV this cycle.
- o_Req_RX_DV  out  2  one-cycle RX byte valid, routed to the granted requester.
- o_Req_RX_Byte  out  8  RX byte; valid when any o_Req_RX_DV bit is set.
- o_Req_Done  out  2  one-cycle pulse after the last RX byte of the transaction.
- o_SPI_TX_Count  out  CNT_W  to master i_TX_Count; the latched transaction count.
- o_SPI_TX_Byte  out  8  to master i_TX_Byte.
- o_SPI_TX_DV  out  1  to master i_TX_DV.
- i_SPI_TX_Ready  in  1  from master o_TX_Ready.
- i_SPI_RX_DV  in  1  from master o_RX_DV.
- i_SPI_RX_Byte  in  8  from master o_RX_Byte.

Behaviour:
- All outputs are registered.
- Reset (async assert, sync deassert): every output 0, state IDLE, round-robin pointer = req0 preferred, all counters cleared. Asserting reset mid-transaction aborts it with no o_Req_Done; the master must be reset together with this block.
- State machine: IDLE -> XFER -> RELEASE -> IDLE.
- IDLE:
  - If i_Req != 0, select a requester: the preferred one if it is requesting, else the other.
  - Latch its count into cnt, clamped to MAX_BYTES_PER_CS.
  - Next cycle: o_Grant[sel]=1, o_SPI_TX_Count=cnt, tx_sent=0, rx_cnt=0, pending=0, state XFER.
  - Pointer toggles to prefer the other requester.
  - Latched count 0: no grant and no SPI traffic; o_Req_Done[sel] pulses the next cycle, the pointer still toggles, state goes to RELEASE.
- XFER, TX side:
  - o_Req_Ready[g] = i_SPI_TX_Ready & ~pending & (tx_sent < cnt); o_Req_Ready of the non-granted bit is 0.
  - i_Req_DV[g] while o_Req_Ready[g] is set: next cycle o_SPI_TX_DV=1 for exactly one cycle, o_SPI_TX_Byte=i_Req_Byte[g]; tx_sent increments and pending is set.
  - Any DV from the non-granted requester, or while Ready is 0, is ignored: no SPI strobe, no counter change.
- XFER, RX side:
  - i_SPI_RX_DV: next cycle o_Req_RX_DV[g]=1 and o_Req_RX_Byte=i_SPI_RX_Byte; rx_cnt increments and pending clears.
  - When rx_cnt reaches cnt: o_Req_Done[g] pulses in the same cycle as the final o_Req_RX_DV[g], o_Grant clears next cycle, state RELEASE.
- RELEASE:
  - Stay at least RELEASE_GAP clocks.
  - Leave only when i_SPI_TX_Ready=1, i.e. the master's CS-inactive gap is over; then go to IDLE.
- i_SPI_RX_DV in IDLE or RELEASE is ignored.
- i_Req[g] dropped mid-transaction: no abort; grant is held until cnt bytes are received.
- Both requesters assert in the same cycle: pointer decides. Continuous requests from both alternate 0,1,0,1.
- Latency: request to grant 1 clock; DV to SPI strobe 1 clock; master RX to requester RX 1 clock.

Test Plan:
- Req0 only: count=2, bytes 0xC1 then 0xC2, MOSI looped to MISO. Expect o_SPI_TX_Count=2 and exactly two o_SPI_TX_DV strobes. Req0 receives 0xC1 then 0xC2; o_Req_Done[0] pulses once, with the 0xC2 RX_DV; CS_n stays low across both bytes.
- Both requesters assert i_Req in the same cycle after reset: req0 (0xA5) is granted first, then req1 (0x5A, count=1). o_Grant is never 2'b11. req1's grant comes only after RELEASE has seen i_SPI_TX_Ready=1.
- Non-granted DV: req1 strobes 0xFF while req0 holds the grant. No o_SPI_TX_DV for 0xFF; req0's 0x3C is sent unaffected.
- Double strobe: req0 pulses i_Req_DV on two consecutive cycles during one byte. Only one SPI strobe and tx_sent=1 until the next o_Req_Ready.
- Count edge cases: count=0 gives o_Req_Done pulse and no SPI activity. count=3 with MAX=2 is clamped: o_SPI_TX_Count=2 and only two bytes accepted.
- Reset asserted mid-XFER after byte 1: outputs are 0 immediately. After release, a fresh req1 transaction completes normally with req0 preferred first.
